// File: rtl/mcu_pkg.sv
// Shared types and constants for the playlist controller.
// The PREV state exists only when MCU_PREV_EN is defined.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_PAUSE,
    ST_PLAY,
    ST_NEXT,
`ifdef MCU_PREV_EN
    ST_PREV,
`endif
    ST_RESTART,
    ST_END
  } state_e;

  localparam logic [1:0] MODE_NORMAL     = 2'd0;
  localparam logic [1:0] MODE_REPEAT_ONE = 2'd1;
  localparam logic [1:0] MODE_REPEAT_ALL = 2'd2;

  // Output vectors ordered {play, NextSong, reset_play, playlist_end}
  localparam logic [3:0] OUT_RESET   = 4'b0010;
  localparam logic [3:0] OUT_PAUSE   = 4'b0000;
  localparam logic [3:0] OUT_PLAY    = 4'b1000;
  localparam logic [3:0] OUT_NEXT    = 4'b0110;
  localparam logic [3:0] OUT_PREV    = 4'b0110;
  localparam logic [3:0] OUT_RESTART = 4'b0010;
  localparam logic [3:0] OUT_END     = 4'b0011;

  function automatic logic [3:0] decode_out(input state_e s);
    logic [3:0] v;
    v = OUT_RESET;
    case (s)
      ST_RESET:   v = OUT_RESET;
      ST_PAUSE:   v = OUT_PAUSE;
      ST_PLAY:    v = OUT_PLAY;
      ST_NEXT:    v = OUT_NEXT;
`ifdef MCU_PREV_EN
      ST_PREV:    v = OUT_PREV;
`endif
      ST_RESTART: v = OUT_RESTART;
      ST_END:     v = OUT_END;
      default:    v = OUT_RESET;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mcu_song_idx_ctr.sv
// Wrap-around song index counter; clr wins over inc, inc wins over dec.
module mcu_song_idx_ctr #(
  parameter  int unsigned NUM_SONGS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_SONGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SONGS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
    end else if (dec) begin
      idx_d = (idx_q == '0) ? LAST : idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  assign idx = idx_q;

endmodule

// File: rtl/mcu_playlist_ctrl.sv
// Moore playlist controller: play/pause, next/prev, end-of-song handling by mode.
// Optional macro MCU_PREV_EN enables the prev button and PREV state.
module mcu_playlist_ctrl
  import mcu_pkg::*;
#(
  parameter  int unsigned NUM_SONGS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_SONGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play_pause,
  input  logic             next,
  input  logic             prev,
  input  logic             song_done,
  input  logic [1:0]       mode,
  output logic             play,
  output logic             reset_play,
  output logic             NextSong,
  output logic [IDX_W-1:0] song_idx,
  output logic             playlist_end
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SONGS - 1);

  state_e state_q, state_d;
  logic   prev_req;
  logic   idx_inc, idx_dec, idx_clr;

`ifdef MCU_PREV_EN
  assign prev_req = prev;
`else
  logic unused_prev;
  assign unused_prev = prev;
  assign prev_req    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // Transient states ignore every input; mode is only looked at on song_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (play_pause) state_d = ST_PLAY;
        else if (next)  state_d = ST_NEXT;
`ifdef MCU_PREV_EN
        else if (prev_req) state_d = ST_PREV;
`endif
      end
      ST_PLAY: begin
        if (play_pause) state_d = ST_PAUSE;
        else if (next)  state_d = ST_NEXT;
`ifdef MCU_PREV_EN
        else if (prev_req) state_d = ST_PREV;
`endif
        else if (song_done) begin
          case (mode)
            MODE_REPEAT_ONE: state_d = ST_RESTART;
            MODE_REPEAT_ALL: state_d = ST_NEXT;
            default:         state_d = (song_idx == LAST_IDX) ? ST_END : ST_NEXT;
          endcase
        end
      end
      ST_NEXT:    state_d = ST_PLAY;
`ifdef MCU_PREV_EN
      ST_PREV:    state_d = ST_PLAY;
`endif
      ST_RESTART: state_d = ST_PLAY;
      ST_END:     state_d = ST_PAUSE;
      default:    state_d = ST_RESET;
    endcase
  end

  // Index moves on the edge that enters NEXT/PREV/END.
  assign idx_inc = (state_d == ST_NEXT);
  assign idx_clr = (state_d == ST_END);
`ifdef MCU_PREV_EN
  assign idx_dec = (state_d == ST_PREV);
`else
  assign idx_dec = 1'b0 & prev_req;
`endif

  mcu_song_idx_ctr #(
    .NUM_SONGS (NUM_SONGS)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .inc   (idx_inc),
    .dec   (idx_dec),
    .clr   (idx_clr),
    .idx   (song_idx)
  );

  assign {play, NextSong, reset_play, playlist_end} = decode_out(state_q);

endmodule

// File: tb/tb_mcu_playlist_ctrl.sv
// Scoreboard bench for mcu_playlist_ctrl (NUM_SONGS=4); honours MCU_PREV_EN.
module tb_mcu_playlist_ctrl;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_pause, next, prev, song_done;
  logic [1:0] mode;
  logic       play, reset_play, NextSong, playlist_end;
  logic [1:0] song_idx;

  typedef struct {
    logic [3:0] out;
    logic [1:0] idx;
    int         due;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  mcu_playlist_ctrl #(.NUM_SONGS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_pause   (play_pause),
    .next         (next),
    .prev         (prev),
    .song_done    (song_done),
    .mode         (mode),
    .play         (play),
    .reset_play   (reset_play),
    .NextSong     (NextSong),
    .song_idx     (song_idx),
    .playlist_end (playlist_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that has come due and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        if ({play, NextSong, reset_play, playlist_end} !== e.out) begin
          errors++;
          $display("FAIL %s outputs {play,NextSong,reset_play,playlist_end}: got %b expected %b",
                   e.name, {play, NextSong, reset_play, playlist_end}, e.out);
        end
        checks++;
        if (song_idx !== e.idx) begin
          errors++;
          $display("FAIL %s song_idx: got %0d expected %0d", e.name, song_idx, e.idx);
        end
      end
    end
  end

  // Drive one cycle of inputs; expectation is for the state after the next edge.
  task automatic step(input logic pp, input logic nx, input logic pv, input logic sd,
                      input logic [3:0] eo, input logic [1:0] ei, input string nm);
    play_pause = pp;
    next       = nx;
    prev       = pv;
    song_done  = sd;
    q.push_back('{eo, ei, cyc + 1, nm});
    @(negedge clk);
  endtask

  task automatic now_chk(input logic [3:0] eo, input logic [1:0] ei, input string nm);
    q.push_back('{eo, ei, cyc, nm});
    -> sample_ev;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; play_pause = 1'b0; next = 1'b0; prev = 1'b0; song_done = 1'b0;
    mode  = MODE_NORMAL;
    repeat (2) @(negedge clk);
    now_chk(4'b0010, 2'd0, "in_reset");
    @(negedge clk);
    reset = 1'b0;
    now_chk(4'b0010, 2'd0, "release_first_cycle");
    step(0, 0, 0, 0, 4'b0000, 2'd0, "idle1_pause");
    step(0, 0, 0, 0, 4'b0000, 2'd0, "idle2_pause");

    // Normal progression through three songs.
    step(1, 0, 0, 0, 4'b1000, 2'd0, "start_play");
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 4'b0110, 2'(i), "done_next");
      step(0, 0, 0, 0, 4'b1000, 2'(i), "done_resume");
    end
    mode = MODE_REPEAT_ALL;
    step(0, 0, 0, 0, 4'b1000, 2'd3, "mode_change_no_effect");
    mode = MODE_NORMAL;
    step(0, 0, 0, 1, 4'b0011, 2'd0, "normal_end");
    step(0, 1, 0, 0, 4'b0000, 2'd0, "end_to_pause_ignores_next");

    // Buttons ignored inside NEXT; walk to the last song.
    step(0, 1, 0, 0, 4'b0110, 2'd1, "pause_next");
    step(1, 0, 0, 0, 4'b1000, 2'd1, "next_ignores_pp");
    step(0, 1, 0, 0, 4'b0110, 2'd2, "play_next");
    step(0, 0, 0, 0, 4'b1000, 2'd2, "play_resume");
    step(0, 1, 0, 0, 4'b0110, 2'd3, "play_next");
    step(0, 0, 0, 0, 4'b1000, 2'd3, "play_resume");
    mode = MODE_REPEAT_ALL;
    step(0, 0, 0, 1, 4'b0110, 2'd0, "repeat_all_wrap");
    step(0, 0, 0, 0, 4'b1000, 2'd0, "repeat_all_play");
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, 4'b0110, 2'(i), "walk_next");
      step(0, 0, 0, 0, 4'b1000, 2'(i), "walk_resume");
    end
    mode = MODE_REPEAT_ONE;
    step(0, 0, 0, 1, 4'b0010, 2'd3, "repeat_one_restart");
    step(0, 0, 0, 0, 4'b1000, 2'd3, "repeat_one_play");
    mode = 2'd3;
    step(0, 0, 0, 1, 4'b0011, 2'd0, "reserved_mode_end");
    step(0, 0, 0, 0, 4'b0000, 2'd0, "reserved_mode_pause");

`ifdef MCU_PREV_EN
    step(0, 0, 1, 0, 4'b0110, 2'd3, "prev_wrap");
    step(0, 0, 0, 0, 4'b1000, 2'd3, "prev_play");
    step(0, 0, 1, 0, 4'b0110, 2'd2, "play_prev");
    step(0, 0, 0, 0, 4'b1000, 2'd2, "prev_resume");
    step(0, 0, 1, 0, 4'b0110, 2'd1, "play_prev");
    step(0, 0, 0, 0, 4'b1000, 2'd1, "prev_resume");
`else
    step(0, 0, 1, 0, 4'b0000, 2'd0, "prev_ignored_pause");
    step(1, 0, 0, 0, 4'b1000, 2'd0, "pause_play");
    step(0, 1, 0, 0, 4'b0110, 2'd1, "next_one");
    step(0, 0, 0, 0, 4'b1000, 2'd1, "next_resume");
    step(0, 0, 1, 0, 4'b1000, 2'd1, "prev_ignored_play");
`endif

    mode = MODE_NORMAL;
    step(0, 1, 0, 1, 4'b0110, 2'd2, "next_and_done");
    step(0, 0, 0, 0, 4'b1000, 2'd2, "single_increment");
    step(1, 0, 0, 0, 4'b0000, 2'd2, "play_to_pause");
    step(0, 1, 0, 0, 4'b0110, 2'd3, "pause_next_before_reset");

    // Reset mid-NEXT, between clock edges.
    #3;
    next  = 1'b0;
    reset = 1'b1;
    now_chk(4'b0010, 2'd0, "async_reset_in_next");
    @(negedge clk);
    now_chk(4'b0010, 2'd0, "reset_held");
    reset = 1'b0;
    step(0, 0, 0, 0, 4'b0000, 2'd0, "after_reset_pause");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
